// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
// The FSM enum carries the PARITY state only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO in front of the transmitter.
// The head entry is visible combinationally so a pop and the consumer's
// load of that byte land on the same clock edge.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = UART_DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_wr;
  logic             do_rd;

  // Status comes from the registered count only; a write while full is
  // dropped even when a pop happens in the same cycle.
  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr_reg];

  // Storage array, no reset needed on the data itself.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_rd) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (do_wr && !do_rd) begin
        count_reg <= count_reg + CW'(1);
      end else if (do_rd && !do_wr) begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffers strobed bytes in a FIFO and shifts each one out
// LSB first as a start/8-data/stop frame on an idle-high line.
// Define UART_TX_PARITY_EN to insert an even parity bit after data bit 7.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_DV,
  input  logic [UART_DATA_W-1:0] i_Tx_Byte,
  output logic                   o_Tx_Serial,
  output logic                   o_Tx_Active,
  output logic                   o_Tx_Done,
  output logic                   o_full,
  output logic                   o_overflow
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] DONE_AT  = 16'(CLKS_PER_BIT - 2);

  tx_state_t              state_reg;
  logic [15:0]            baud_cnt_reg;
  logic [2:0]             bit_idx_reg;
  logic [UART_DATA_W-1:0] shift_reg;
`ifdef UART_TX_PARITY_EN
  logic                   parity_reg;
`endif
  logic                   overflow_reg;

  logic                   fifo_rd;
  logic                   fifo_empty;
  logic [UART_DATA_W-1:0] fifo_data;
  logic                   bit_end;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (i_DV),
    .wr_data (i_Tx_Byte),
    .rd_en   (fifo_rd),
    .rd_data (fifo_data),
    .full    (o_full),
    .empty   (fifo_empty)
  );

  assign bit_end = (baud_cnt_reg == BIT_LAST);

  // Pop from idle, or at the end of a stop bit so frames run back to back.
  assign fifo_rd = !fifo_empty &&
                   ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && bit_end));

  assign o_overflow = overflow_reg;

  // Flag a strobe that arrived while the FIFO had no room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= i_DV && o_full;
    end
  end

  // Frame sequencer; the line value is registered one edge ahead of each bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
      o_Tx_Serial  <= 1'b1;
      o_Tx_Active  <= 1'b0;
      o_Tx_Done    <= 1'b0;
    end else begin
      o_Tx_Done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          baud_cnt_reg <= '0;
          o_Tx_Serial  <= 1'b1;
          if (fifo_rd) begin
            shift_reg   <= fifo_data;
            bit_idx_reg <= '0;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= ^fifo_data;
`endif
            o_Tx_Serial <= 1'b0;
            o_Tx_Active <= 1'b1;
            state_reg   <= ST_START;
          end
        end

        ST_START: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            o_Tx_Serial  <= shift_reg[0];
            state_reg    <= ST_DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 16'd1;
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            shift_reg    <= shift_reg >> 1;
            if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              o_Tx_Serial <= parity_reg;
              state_reg   <= ST_PARITY;
`else
              o_Tx_Serial <= 1'b1;
              state_reg   <= ST_STOP;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              o_Tx_Serial <= shift_reg[1];
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 16'd1;
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            o_Tx_Serial  <= 1'b1;
            state_reg    <= ST_STOP;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 16'd1;
          end
        end
`endif

        ST_STOP: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            if (fifo_rd) begin
              shift_reg   <= fifo_data;
              bit_idx_reg <= '0;
`ifdef UART_TX_PARITY_EN
              parity_reg  <= ^fifo_data;
`endif
              o_Tx_Serial <= 1'b0;
              state_reg   <= ST_START;
            end else begin
              o_Tx_Active <= 1'b0;
              state_reg   <= ST_IDLE;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 16'd1;
            // Registered, so raise it one edge early to cover the final cycle.
            if (baud_cnt_reg == DONE_AT) begin
              o_Tx_Done <= 1'b1;
            end
          end
        end

        default: begin
          baud_cnt_reg <= '0;
          o_Tx_Serial  <= 1'b1;
          o_Tx_Active  <= 1'b0;
          state_reg    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: a frame-position reference model predicts every
// output each cycle; directed scenarios add frame-count and length checks.
module tb_uart_tx;

  localparam int C = 4;
  localparam int D = 4;
`ifdef UART_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif
  localparam int FL = F * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_DV = 1'b0;
  logic [7:0] i_Tx_Byte = 8'h00;
  logic       o_Tx_Serial;
  logic       o_Tx_Active;
  logic       o_Tx_Done;
  logic       o_full;
  logic       o_overflow;

  uart_tx #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_DV        (i_DV),
    .i_Tx_Byte   (i_Tx_Byte),
    .o_Tx_Serial (o_Tx_Serial),
    .o_Tx_Active (o_Tx_Active),
    .o_Tx_Done   (o_Tx_Done),
    .o_full      (o_full),
    .o_overflow  (o_overflow)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;
  bit chk_on = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    chk_cnt++;
    if (obs == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: queue of accepted bytes and the position within the
  // frame currently on the line.
  logic [7:0] mq[$];
  bit         m_busy = 1'b0;
  int         m_pos = 0;
  logic       m_bits [0:10];
  int         m_frames = 0;
  logic       e_serial = 1'b1;
  logic       e_active = 1'b0;
  logic       e_done = 1'b0;
  logic       e_full = 1'b0;
  logic       e_ovf = 1'b0;

  initial begin : model
    int         sz;
    logic       dv;
    logic [7:0] d;
    logic [7:0] h;
    bit         ending;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_busy   = 1'b0;
        m_pos    = 0;
        e_serial = 1'b1;
        e_active = 1'b0;
        e_done   = 1'b0;
        e_full   = 1'b0;
        e_ovf    = 1'b0;
      end else begin
        sz     = mq.size();
        dv     = i_DV;
        d      = i_Tx_Byte;
        ending = m_busy && (m_pos == FL - 1);
        if (ending) m_frames++;
        if (sz > 0 && (!m_busy || ending)) begin
          h = mq.pop_front();
          m_bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) m_bits[i+1] = h[i];
          m_bits[9]  = ^h;
          m_bits[F-1] = 1'b1;
          m_busy = 1'b1;
          m_pos  = 0;
        end else if (ending) begin
          m_busy = 1'b0;
        end else if (m_busy) begin
          m_pos++;
        end
        e_ovf = dv && (sz == D);
        if (dv && sz < D) mq.push_back(d);
        e_full   = (mq.size() == D);
        e_serial = m_busy ? m_bits[m_pos / C] : 1'b1;
        e_active = m_busy;
        e_done   = m_busy && (m_pos == FL - 1);
      end
    end
  end

  // Per-cycle comparison and simple line statistics.
  int run_len = 0;
  int last_run = 0;
  int done_cnt = 0;
  int ovf_cnt = 0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (chk_on) begin
        check("serial",   int'(o_Tx_Serial), int'(e_serial));
        check("active",   int'(o_Tx_Active), int'(e_active));
        check("done",     int'(o_Tx_Done),   int'(e_done));
        check("full",     int'(o_full),      int'(e_full));
        check("overflow", int'(o_overflow),  int'(e_ovf));
      end
      if (o_Tx_Active) run_len++;
      else begin
        if (run_len != 0) last_run = run_len;
        run_len = 0;
      end
      if (o_Tx_Done) begin
        done_cnt++;
        $display("frame %0d done at %0t", done_cnt, $time);
      end
      if (o_overflow) ovf_cnt++;
    end
  end

  task automatic drive(input logic dv, input logic [7:0] b);
    @(posedge clk);
    #1;
    i_DV = dv;
    i_Tx_Byte = b;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 8'h00);
    repeat (n) @(posedge clk);
  endtask

  int d0;
  int o0;

  initial begin : stim
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_serial",   int'(o_Tx_Serial), 1);
    check("rst_active",   int'(o_Tx_Active), 0);
    check("rst_done",     int'(o_Tx_Done),   0);
    check("rst_full",     int'(o_full),      0);
    check("rst_overflow", int'(o_overflow),  0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_on = 1'b1;
    idle(3);

    // Single byte 0xA5
    d0 = done_cnt;
    drive(1'b1, 8'hA5);
    idle(FL + 5);
    check("a5_done_cnt", done_cnt - d0, 1);
    check("a5_frame_len", last_run, FL);

    // Three contiguous frames
    d0 = done_cnt;
    drive(1'b1, 8'h00);
    drive(1'b1, 8'hFF);
    drive(1'b1, 8'h55);
    idle(3 * FL + 10);
    check("three_done_cnt", done_cnt - d0, 3);
    check("three_active_run", last_run, 3 * FL);

    // Six back-to-back writes: one popped, four buffered, one dropped
    d0 = done_cnt;
    o0 = ovf_cnt;
    for (int i = 0; i < 6; i++) drive(1'b1, 8'($urandom));
    idle(5 * FL + 10);
    check("six_done_cnt", done_cnt - d0, 5);
    check("six_overflow_cnt", ovf_cnt - o0, 1);
    check("six_active_run", last_run, 5 * FL);

    // Reset in the middle of data bit 3 of 0x3C with two bytes queued
    d0 = done_cnt;
    drive(1'b1, 8'h3C);
    drive(1'b1, 8'h11);
    drive(1'b1, 8'h22);
    drive(1'b0, 8'h00);
    repeat (16) @(posedge clk);
    #1 check("mid_active", int'(o_Tx_Active), 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_serial",   int'(o_Tx_Serial), 1);
    check("arst_active",   int'(o_Tx_Active), 0);
    check("arst_done",     int'(o_Tx_Done),   0);
    check("arst_full",     int'(o_full),      0);
    check("arst_overflow", int'(o_overflow),  0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3 * FL);
    check("arst_no_frames", done_cnt - d0, 0);

`ifdef UART_TX_PARITY_EN
    // Parity bit sits at frame positions 36..39
    drive(1'b1, 8'h07);
    drive(1'b0, 8'h00);
    repeat (38) @(posedge clk);
    #1 check("parity_07", int'(o_Tx_Serial), 1);
    idle(10);
    check("parity_frame_len", last_run, 44);
    drive(1'b1, 8'h03);
    drive(1'b0, 8'h00);
    repeat (38) @(posedge clk);
    #1 check("parity_03", int'(o_Tx_Serial), 0);
    idle(10);
`endif

    // Sparse random traffic
    for (int i = 0; i < 1500; i++)
      drive(($urandom_range(0, 24) == 0), 8'($urandom));
    // Dense random bursts to exercise full and overflow
    for (int i = 0; i < 200; i++)
      drive(($urandom_range(0, 1) == 0), 8'($urandom));
    idle((D + 2) * FL);
    check("total_frames", done_cnt, m_frames);
    check("final_idle", int'(o_Tx_Active), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
